// File: rtl/row_matrix_scanner.sv
// rtl/row_matrix_scanner.sv - time-multiplexed LED row scanner with per-frame snapshot
module row_matrix_scanner #(
  parameter int NUM_ROWS = 16,
  parameter int COLS     = 16,
  parameter int DWELL    = 512,
  parameter int BLANK    = 4,
  localparam int IDX_W   = $clog2(NUM_ROWS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [NUM_ROWS*COLS-1:0] i_rows_in,
  output logic [NUM_ROWS-1:0]      o_row_sel_n,
  output logic [COLS-1:0]          o_col_out,
  output logic [IDX_W-1:0]         o_row_idx,
  output logic                     o_frame_start,
  output logic                     o_frame_done
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [IDX_W-1:0]    ROW_LAST   = IDX_W'(NUM_ROWS - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE    = NUM_ROWS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNAP  = 2'd1,
    S_DRIVE = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_row_idx;
  logic [NUM_ROWS*COLS-1:0]   r_snapshot;
  logic [NUM_ROWS-1:0]        r_row_sel_n;
  logic [COLS-1:0]            r_col_out;
  logic                       r_frame_start;
  logic                       r_frame_done;

  state_t                     w_state_nx;
  logic [CNT_W-1:0]           w_cnt_nx;
  logic [IDX_W-1:0]           w_row_nx;
  logic [NUM_ROWS*COLS-1:0]   w_snap_nx;
  logic [NUM_ROWS-1:0]        w_row_sel_nx;
  logic [COLS-1:0]            w_col_nx;
  logic                       w_frame_start_nx;
  logic                       w_frame_done_nx;

  // State, counters, snapshot and the output registers; reset blanks the matrix at once
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_row_idx     <= '0;
      r_snapshot    <= '0;
      r_row_sel_n   <= '1;
      r_col_out     <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_row_idx     <= w_row_nx;
      r_snapshot    <= w_snap_nx;
      r_row_sel_n   <= w_row_sel_nx;
      r_col_out     <= w_col_nx;
      r_frame_start <= w_frame_start_nx;
      r_frame_done  <= w_frame_done_nx;
    end
  end

  // Next state: dwell/blank counting per row, enable looked at only in IDLE and at frame end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_row_nx   = r_row_idx;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_row_nx = '0;
        if (i_enable) w_state_nx = S_SNAP;
      end
      S_SNAP: begin
        w_cnt_nx   = '0;
        w_row_nx   = '0;
        w_state_nx = S_DRIVE;
      end
      S_DRIVE: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_BLANK;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_cnt_nx = '0;
          if (r_row_idx == ROW_LAST) begin
            w_row_nx   = '0;
            w_state_nx = i_enable ? S_SNAP : S_IDLE;
          end else begin
            w_row_nx   = r_row_idx + 1'b1;
            w_state_nx = S_DRIVE;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_row_nx   = '0;
      end
    endcase
  end

  // Next outputs derived from the next state so the registered outputs track the state exactly
  always_comb begin
    w_snap_nx        = (r_state == S_SNAP) ? i_rows_in : r_snapshot;
    w_row_sel_nx     = '1;
    w_col_nx         = '0;
    w_frame_start_nx = (w_state_nx == S_SNAP);
    w_frame_done_nx  = (w_state_nx == S_BLANK) && (w_row_nx == ROW_LAST) &&
                       (w_cnt_nx == BLANK_LAST);
    if (w_state_nx == S_DRIVE) begin
      w_row_sel_nx = ~(ROW_ONE << w_row_nx);
      w_col_nx     = w_snap_nx[int'(w_row_nx) * COLS +: COLS];
    end
  end

  assign o_row_sel_n   = r_row_sel_n;
  assign o_col_out     = r_col_out;
  assign o_row_idx     = r_row_idx;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;

endmodule

// File: tb/tb_row_matrix_scanner.sv
// tb/tb_row_matrix_scanner.sv - randomized self-checking bench for row_matrix_scanner
module tb_row_matrix_scanner;

  localparam int NR = 16;
  localparam int NC = 16;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int RP = DW + BL;
  localparam int FP = NR * RP + 1;

  localparam logic [37:0] IDLE_OBS = {16'hFFFF, 16'h0000, 4'd0, 1'b0, 1'b0};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [NR*NC-1:0] rows_in = '0;
  logic [NR-1:0]  row_sel_n;
  logic [NC-1:0]  col_out;
  logic [3:0]     row_idx;
  logic           frame_start;
  logic           frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] cur_rows [NR];
  logic [15:0] m_snap   [NR];

  row_matrix_scanner #(
    .NUM_ROWS(NR),
    .COLS    (NC),
    .DWELL   (DW),
    .BLANK   (BL)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_enable     (enable),
    .i_rows_in    (rows_in),
    .o_row_sel_n  (row_sel_n),
    .o_col_out    (col_out),
    .o_row_idx    (row_idx),
    .o_frame_start(frame_start),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected {row_sel_n, col_out, row_idx, frame_start, frame_done} at cycle t of a frame (t=0 is SNAP)
  function automatic logic [37:0] model_at(input int t);
    int r;
    int p;
    logic [15:0] sel;
    logic [15:0] col;
    if (t == 0) return {16'hFFFF, 16'h0000, 4'd0, 1'b1, 1'b0};
    r   = (t - 1) / RP;
    p   = (t - 1) % RP;
    sel = 16'hFFFF;
    col = 16'h0000;
    if (p < DW) begin
      sel = ~(16'h0001 << r);
      col = m_snap[r];
    end
    return {sel, col, 4'(r), 1'b0, ((r == NR - 1) && (p == RP - 1))};
  endfunction

  function automatic logic [37:0] obs();
    return {row_sel_n, col_out, row_idx, frame_start, frame_done};
  endfunction

  task automatic apply_rows();
    for (int r = 0; r < NR; r++) rows_in[r*NC +: NC] = cur_rows[r];
  endtask

  task automatic random_rows();
    for (int r = 0; r < NR; r++) cur_rows[r] = 16'($urandom());
    apply_rows();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required %h", i, obs(), IDLE_OBS);
      end
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", i, obs(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_single_frame();
    for (int r = 0; r < NR; r++) cur_rows[r] = 16'h8000 >> r;
    apply_rows();
    m_snap = cur_rows;
    enable = 1'b1;
    for (int t = 0; t < FP; t++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== model_at(t)) begin
        n_fail++;
        $display("FAIL single_frame t=%0d: got %h required %h", t, obs(), model_at(t));
      end
      if (t == 0) enable = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL single_frame_idle cycle %0d: got %h required %h", i, obs(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_no_tearing();
    for (int r = 0; r < NR; r++) cur_rows[r] = 16'h8000 >> r;
    apply_rows();
    m_snap = cur_rows;
    enable = 1'b1;
    for (int t = 0; t < 2 * FP; t++) begin
      @(negedge clk);
      if (t == FP) m_snap = cur_rows;
      n_checks++;
      if (obs() !== model_at(t % FP)) begin
        n_fail++;
        $display("FAIL no_tearing t=%0d: got %h required %h", t, obs(), model_at(t % FP));
      end
      if (t == 1 + 3 * RP + 1) begin
        for (int r = 0; r < NR; r++) cur_rows[r] = 16'hFFFF;
        apply_rows();
      end
      if (t == FP) enable = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL no_tearing_idle: got %h required %h", obs(), IDLE_OBS);
    end
  endtask

  task automatic test_enable_drop();
    random_rows();
    m_snap = cur_rows;
    enable = 1'b1;
    for (int t = 0; t < FP; t++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== model_at(t)) begin
        n_fail++;
        $display("FAIL enable_drop t=%0d: got %h required %h", t, obs(), model_at(t));
      end
      if (t == 1 + 5 * RP + 1) enable = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL enable_drop_idle cycle %0d: got %h required %h", i, obs(), IDLE_OBS);
      end
    end
  endtask

  task automatic test_back_to_back();
    int chg;
    int last_fs;
    last_fs = -1;
    chg     = 1;
    random_rows();
    enable = 1'b1;
    for (int t = 0; t < 3 * FP; t++) begin
      @(negedge clk);
      if (t % FP == 0) begin
        m_snap = cur_rows;
        chg    = int'($urandom_range(1, FP - 1));
      end
      n_checks++;
      if (obs() !== model_at(t % FP)) begin
        n_fail++;
        $display("FAIL back_to_back t=%0d: got %h required %h", t, obs(), model_at(t % FP));
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (t - last_fs !== FP) begin
            n_fail++;
            $display("FAIL frame_period: got %0d required %0d", t - last_fs, FP);
          end
        end
        last_fs = t;
      end
      if (t % FP == chg) random_rows();
      if (t == 2 * FP + 1) enable = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL back_to_back_idle: got %h required %h", obs(), IDLE_OBS);
    end
  endtask

  task automatic test_async_reset();
    random_rows();
    m_snap = cur_rows;
    enable = 1'b1;
    for (int t = 0; t <= 1 + 7 * RP + 1; t++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== model_at(t)) begin
        n_fail++;
        $display("FAIL async_pre t=%0d: got %h required %h", t, obs(), model_at(t));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h required %h", obs(), IDLE_OBS);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== IDLE_OBS) begin
        n_fail++;
        $display("FAIL async_reset_hold cycle %0d: got %h required %h", i, obs(), IDLE_OBS);
      end
    end
    rst_n = 1'b1;
    for (int t = 0; t < FP; t++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== model_at(t)) begin
        n_fail++;
        $display("FAIL async_restart t=%0d: got %h required %h", t, obs(), model_at(t));
      end
      if (t == 0) enable = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (obs() !== IDLE_OBS) begin
      n_fail++;
      $display("FAIL async_restart_idle: got %h required %h", obs(), IDLE_OBS);
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      cur_rows[r] = 16'h0000;
      m_snap[r]   = 16'h0000;
    end
    test_reset();
    test_single_frame();
    test_no_tearing();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
